// File: rtl/register_bank_arbiter_if.sv
// Requester, response and bank-side signals shared between the arbiter and its environment.
// master = requesters plus bank model; slave = the arbiter itself.
interface register_bank_arbiter_if #(
  parameter int ADDR_W = 3
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [15:0]       req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [15:0]       rsp0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [15:0]       req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [15:0]       rsp1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_in;
  logic              mem_load;
  logic [15:0]       mem_out;

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_addr, mem_in, mem_load,
    output mem_out
  );

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_addr, mem_in, mem_load,
    input  mem_out
  );
endinterface

// File: rtl/register_bank_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared 16-bit register bank.
// Each accepted operation takes one IDLE sampling cycle plus one SERVE cycle.
module register_bank_arbiter #(
  parameter int ADDR_W = 3
) (
  input logic                    clock,
  input logic                    reset,
  register_bank_arbiter_if.slave bus
);
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              win_s;
  logic              sel_write_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [15:0]       sel_wdata_s;

  logic              last_grant_r;
  logic              win_r;
  logic              load_r;
  logic              ready0_r;
  logic              ready1_r;
  logic              rsp0_valid_r;
  logic              rsp1_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [15:0]       mem_in_r;
  logic [15:0]       rsp0_rdata_r;
  logic [15:0]       rsp1_rdata_r;

  // Next-state logic and round-robin winner selection
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    win_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          accept_s    = 1'b1;
          win_s       = ~last_grant_r;
          state_nxt_s = SERVE;
        end else if (bus.req0_valid) begin
          accept_s    = 1'b1;
          win_s       = 1'b0;
          state_nxt_s = SERVE;
        end else if (bus.req1_valid) begin
          accept_s    = 1'b1;
          win_s       = 1'b1;
          state_nxt_s = SERVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request field mux for the selected winner
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = 16'h0000;
    if (win_s) begin
      sel_write_s = bus.req1_write;
      sel_addr_s  = bus.req1_addr;
      sel_wdata_s = bus.req1_wdata;
    end else begin
      sel_write_s = bus.req0_write;
      sel_addr_s  = bus.req0_addr;
      sel_wdata_s = bus.req0_wdata;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the accepted operation; the bank lines carry it only during SERVE
  always_ff @(posedge clock) begin
    if (reset) begin
      win_r      <= 1'b0;
      load_r     <= 1'b0;
      ready0_r   <= 1'b0;
      ready1_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_in_r   <= 16'h0000;
    end else if (accept_s) begin
      win_r      <= win_s;
      load_r     <= sel_write_s;
      ready0_r   <= ~win_s;
      ready1_r   <= win_s;
      mem_addr_r <= sel_addr_s;
      mem_in_r   <= sel_wdata_s;
    end else begin
      load_r     <= 1'b0;
      ready0_r   <= 1'b0;
      ready1_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_in_r   <= 16'h0000;
    end
  end

  // Grant history and read-response capture at the end of SERVE
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= 1'b1;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp0_rdata_r <= 16'h0000;
      rsp1_rdata_r <= 16'h0000;
    end else begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      if (state_r == SERVE) begin
        last_grant_r <= win_r;
        if (!load_r) begin
          if (win_r) begin
            rsp1_valid_r <= 1'b1;
            rsp1_rdata_r <= bus.mem_out;
          end else begin
            rsp0_valid_r <= 1'b1;
            rsp0_rdata_r <= bus.mem_out;
          end
        end
      end
    end
  end

  assign bus.req0_ready = ready0_r;
  assign bus.req1_ready = ready1_r;
  assign bus.rsp0_valid = rsp0_valid_r;
  assign bus.rsp1_valid = rsp1_valid_r;
  assign bus.rsp0_rdata = rsp0_rdata_r;
  assign bus.rsp1_rdata = rsp1_rdata_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_in     = mem_in_r;
  // Reset gates the write strobe directly so a SERVE cut short by reset never writes
  assign bus.mem_load   = load_r & ~reset;
endmodule
